// File: rtl/fft64_peak_detect.sv
// Peak-bin detector for a natural-order FFT64 output stream.
// Optional macro PEAK_EXCLUDE_DC_EN removes bin 0 from peak selection.
module fft64_peak_detect #(
    parameter int FFT_size  = 64,
    parameter int IN_width  = 16,
    parameter int GAP_LIMIT = 130
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    input  logic signed [IN_width-1:0] din_r,
    input  logic signed [IN_width-1:0] din_i,
    output logic                       out_valid,
    output logic [5:0]                 peak_idx,
    output logic [2*IN_width-1:0]      peak_mag,
    output logic                       frame_err
);

    localparam int W  = IN_width;
    localparam int MW = 2 * IN_width;
    localparam int GW = $clog2(GAP_LIMIT + 1);

    localparam logic [5:0]    LAST_BIN = 6'(FFT_size - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_LIMIT - 1);

`ifdef PEAK_EXCLUDE_DC_EN
    localparam logic [5:0] FIRST_BIN = 6'd1;
`else
    localparam logic [5:0] FIRST_BIN = 6'd0;
`endif

    typedef enum logic [1:0] {
        IDLE,
        ACC,
        FLUSH
    } state_t;

    state_t          state_q, state_d;
    logic [5:0]      bin_q, bin_d;
    logic [GW-1:0]   gap_q, gap_d;
    logic            abort;

    // stage 0: sampled bin
    logic            v0;
    logic [5:0]      idx0;
    logic signed [W-1:0] d_r, d_i;

    // stage 1: squares
    logic            v1;
    logic [5:0]      idx1;
    logic [MW-1:0]   sq_r, sq_i;

    // stage 2: running max
    logic            done2;
    logic [5:0]      max_idx;
    logic [MW-1:0]   max_mag;

    logic signed [MW-1:0] ext_r, ext_i;
    logic [MW-1:0]   sq_r_d, sq_i_d;
    logic [MW-1:0]   mag;

    assign ext_r  = {{W{d_r[W-1]}}, d_r};
    assign ext_i  = {{W{d_i[W-1]}}, d_i};
    assign sq_r_d = $unsigned(ext_r * ext_r);
    assign sq_i_d = $unsigned(ext_i * ext_i);
    assign mag    = sq_r + sq_i;

    // frame state, bin position and gap counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            bin_q   <= '0;
            gap_q   <= '0;
        end else begin
            state_q <= state_d;
            bin_q   <= bin_d;
            gap_q   <= gap_d;
        end
    end

    // frame sequencing: bin counting, gap timeout, flush tracking
    always_comb begin
        state_d = state_q;
        bin_d   = bin_q;
        gap_d   = '0;
        abort   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_d = ACC;
                    bin_d   = 6'd1;
                end
            end
            ACC: begin
                if (in_valid) begin
                    if (bin_q == LAST_BIN) begin
                        state_d = FLUSH;
                        bin_d   = '0;
                    end else begin
                        bin_d = bin_q + 6'd1;
                    end
                end else if (gap_q == GAP_LAST) begin
                    abort   = 1'b1;
                    state_d = IDLE;
                    bin_d   = '0;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            FLUSH: begin
                if (in_valid) begin
                    state_d = ACC;
                    bin_d   = 6'd1;
                end else if (done2) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                bin_d   = '0;
            end
        endcase
    end

    // stages 0 and 1: capture the bin, then register its squares
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v0   <= 1'b0;
            idx0 <= '0;
            d_r  <= '0;
            d_i  <= '0;
            v1   <= 1'b0;
            idx1 <= '0;
            sq_r <= '0;
            sq_i <= '0;
        end else begin
            v0   <= in_valid && !abort;
            idx0 <= bin_q;
            d_r  <= din_r;
            d_i  <= din_i;
            v1   <= v0 && !abort;
            idx1 <= idx0;
            sq_r <= sq_r_d;
            sq_i <= sq_i_d;
        end
    end

    // stage 2: sum and running-max update; earlier index wins ties
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done2   <= 1'b0;
            max_idx <= '0;
            max_mag <= '0;
        end else begin
            done2 <= v1 && (idx1 == LAST_BIN) && !abort;
            if (v1 && !abort) begin
                if (idx1 == FIRST_BIN) begin
                    max_idx <= idx1;
                    max_mag <= mag;
                end else if (idx1 > FIRST_BIN && mag > max_mag) begin
                    max_idx <= idx1;
                    max_mag <= mag;
                end
            end
        end
    end

    // stage 3: publish result or report an aborted frame
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            frame_err <= 1'b0;
            peak_idx  <= '0;
            peak_mag  <= '0;
        end else begin
            out_valid <= done2 && !abort;
            frame_err <= abort;
            if (done2 && !abort) begin
                peak_idx <= max_idx;
                peak_mag <= max_mag;
            end
        end
    end

endmodule

// File: doc/fft64_peak_detect.md
FFT64_PEAK_DETECT -- requirements
Module: fft64_peak_detect

Interface
REQ-001 SHALL have parameter FFT_size, default 64, meaning bins per frame.
REQ-002 SHALL have parameter IN_width, default 16, meaning signed width of each bin component.
REQ-003 SHALL have parameter GAP_LIMIT, default 130, meaning the maximum run of consecutive idle cycles allowed inside a frame.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-006 SHALL have port in_valid, input, 1 bit: din_r/din_i carry one bin this cycle; driven by the FFT64 out_valid.
REQ-007 SHALL have port din_r, input, IN_width bits, signed: real part of the bin.
REQ-008 SHALL have port din_i, input, IN_width bits, signed: imaginary part of the bin.
REQ-009 SHALL have port out_valid, output, 1 bit: one-cycle pulse, peak result valid.
REQ-010 SHALL have port peak_idx, output, 6 bits: bin index of the peak.
REQ-011 SHALL have port peak_mag, output, 2*IN_width bits, unsigned: squared magnitude of the peak.
REQ-012 SHALL have port frame_err, output, 1 bit: one-cycle pulse, frame aborted on gap timeout.

Function
REQ-013 SHALL treat bins as arriving in natural order 0..FFT_size-1, one per cycle in which in_valid is high; the bin counter advances only on in_valid and wraps 63->0.
REQ-014 SHALL compute mag = din_r*din_r + din_i*din_i, unsigned, 2*IN_width bits, with no saturation; (-32768,-32768) yields 0x80000000.
REQ-015 SHALL use a 2-stage pipeline: the squares are registered at the edge after sampling, and the sum/compare/update happens on the following edge.
REQ-016 SHALL load the running max unconditionally with bin 0 of each frame, then replace it only when mag is strictly greater, so ties keep the lowest index.
REQ-017 SHALL assert out_valid for exactly one cycle, 3 rising edges after the edge that samples bin 63; peak_idx and peak_mag change only at that edge and hold until the next result.
REQ-018 SHALL run FSM states IDLE, ACC (bins 1..63 pending) and FLUSH (pipeline draining); transitions are IDLE->ACC on bin 0, ACC->FLUSH on bin 63, FLUSH->IDLE after the result.
REQ-019 SHALL accept bin 0 of the next frame on the cycle immediately after bin 63 (FLUSH->ACC); back-to-back frames SHALL produce results exactly 64 cycles apart without corruption.
REQ-020 SHALL maintain a gap counter in ACC that counts consecutive cycles with in_valid low and clears on any in_valid.
REQ-021 SHALL, when the gap counter reaches GAP_LIMIT, pulse frame_err for one cycle, discard the partial frame and any in-flight pipeline data, suppress out_valid, return to IDLE, and reset the bin counter to 0.
REQ-022 SHALL treat in_valid in IDLE as bin 0.
REQ-023 SHALL never assert out_valid and frame_err in the same cycle.

Reset
REQ-024 SHALL, while rst_n is low and independent of clk, set out_valid=0, frame_err=0, peak_idx=0, peak_mag=0, FSM=IDLE, bin and gap counters to 0, and clear the pipeline registers.
REQ-025 SHALL, on reset asserted mid-frame, discard that frame with no out_valid and no frame_err; the first in_valid after release is bin 0.

Configuration
REQ-026 SHALL, with macro PEAK_EXCLUDE_DC_EN defined, exclude bin 0 from peak selection: the running max loads with bin 1, and bin 0 is counted but never compared.
REQ-027 SHALL, without PEAK_EXCLUDE_DC_EN, treat bin 0 as eligible per REQ-016; latency and all other behaviour are identical in both builds.

Verification
REQ-028 SHALL cover single tone: bin 5=(1000,0), all other bins 0 -> one out_valid 3 cycles after bin 63, peak_idx=5, peak_mag=1000000.
REQ-029 SHALL cover tie: bins 10 and 40 both (300,-400), all others (1,1) -> peak_idx=10, peak_mag=250000.
REQ-030 SHALL cover extreme: bin 63=(-32768,-32768), all others (100,100) -> peak_idx=63, peak_mag=0x80000000.
REQ-031 SHALL cover gap: 20 bins, then in_valid low for 130 cycles -> frame_err pulse on the 130th idle cycle and no out_valid; the next full frame with peak bin 9 -> peak_idx=9.
REQ-032 SHALL cover back-to-back: frame A peak bin 3, frame B peak bin 60, no idle cycle between them -> out_valid pulses 64 cycles apart reporting 3, then 60; also a reset asserted at bin 30 -> no output, and the next frame is correct.
REQ-033 SHALL cover DC: bin 0=(5000,0), bin 7=(10,0), others 0 -> without the macro peak_idx=0, peak_mag=25000000; with PEAK_EXCLUDE_DC_EN peak_idx=7, peak_mag=100.
